// File: rtl/shift_pkg.sv
// Shared types for the sequential shift register.
// Operation codes, FSM states and the op validity helper.
package shift_pkg;

    typedef enum logic [2:0] {
        SLL = 3'd0,
        SRL = 3'd1,
        SRA = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_e;

    // Codes 5..7 are reserved and complete without touching the register.
    function automatic logic op_valid(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

endpackage

// File: rtl/seq_shift_reg_if.sv
// Load/start/busy/done bus between a controller and seq_shift_reg.
// The master drives requests; the slave returns register state.
interface seq_shift_reg_if #(
    parameter int WIDTH = 16
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               ld;
    logic [WIDTH-1:0]   din;
    logic               start;
    logic [2:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   dout;
    logic               busy;
    logic               done;

    modport master (
        output ld, din, start, op, shamt,
        input  dout, busy, done
    );

    modport slave (
        input  ld, din, start, op, shamt,
        output dout, busy, done
    );

endinterface

// File: rtl/shift_step.sv
// One-bit shift/rotate step.
// Reserved codes pass the operand through.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] din,
    input  shift_op_e        op,
    output logic [WIDTH-1:0] dout
);

    // Pick the one-bit result for the requested operation.
    always_comb begin
        dout = din;
        unique case (1'b1)
            (op == SLL): dout = {din[WIDTH-2:0], 1'b0};
            (op == SRL): dout = {1'b0, din[WIDTH-1:1]};
            (op == SRA): dout = {din[WIDTH-1], din[WIDTH-1:1]};
            (op == ROL): dout = {din[WIDTH-2:0], din[WIDTH-1]};
            (op == ROR): dout = {din[0], din[WIDTH-1:1]};
            default:     dout = din;
        endcase
    end

endmodule

// File: rtl/seq_shift_reg.sv
// Parallel-load register with a one-bit-per-clock shifter.
// Start/busy/done handshake; N-bit shift takes N+1 busy cycles.
module seq_shift_reg
    import shift_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = 20
) (
    input  logic            clk,
    input  logic            rst,
    seq_shift_reg_if.slave  bus
);

    localparam int SHAMT_W = $clog2(WIDTH);

    shift_state_e       state, state_n;
    logic [WIDTH-1:0]   dout_q, dout_n;
    logic [SHAMT_W-1:0] cnt_q, cnt_n;
    shift_op_e          op_q, op_n;
    logic [WIDTH-1:0]   step;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .din  (dout_q),
        .op   (op_q),
        .dout (step)
    );

    // State and datapath registers; reset aborts any shift in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dout_q <= RST_VAL;
            cnt_q  <= '0;
            op_q   <= SLL;
        end else begin
            state  <= state_n;
            dout_q <= dout_n;
            cnt_q  <= cnt_n;
            op_q   <= op_n;
        end
    end

    // Next state: load beats start in IDLE; requests are dropped while busy.
    always_comb begin
        state_n = state;
        dout_n  = dout_q;
        cnt_n   = cnt_q;
        op_n    = op_q;
        unique case (state)
            IDLE: begin
                if (bus.ld) begin
                    dout_n = bus.din;
                end else if (bus.start) begin
                    op_n = shift_op_e'(bus.op);
                    if (bus.shamt != '0 && op_valid(bus.op)) begin
                        cnt_n   = bus.shamt;
                        state_n = SHIFT;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            SHIFT: begin
                dout_n = step;
                cnt_n  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.dout = dout_q;
    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);

endmodule

// File: tb/tb_seq_shift_reg.sv
// Directed bench for seq_shift_reg with a result scoreboard.
// Expected results come from a whole-word shift model.
module tb_seq_shift_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_q[$];
    logic [15:0] model;

    seq_shift_reg_if #(.WIDTH(16)) bus ();

    seq_shift_reg #(
        .WIDTH   (16),
        .RST_VAL (16'd20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] v,
                                              input logic [2:0] op,
                                              input int n);
        logic [31:0] dbl;
        dbl = {v, v};
        case (op)
            3'd0: return v << n;
            3'd1: return v >> n;
            3'd2: return 16'($signed(v) >>> n);
            3'd3: return 16'(dbl >> (16 - n));
            3'd4: return 16'(dbl >> n);
            default: return v;
        endcase
    endfunction

    task automatic do_load(input logic [15:0] d);
        bus.ld  = 1'b1;
        bus.din = d;
        tick();
        bus.ld  = 1'b0;
        model   = d;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [3:0] sh, input bit inject_ld);
        int busy_cnt;
        int done_cnt;
        int exp_busy;
        bit finished;
        logic [15:0] got;
        logic [15:0] want;
        model = ref_shift(model, op, int'(sh));
        exp_q.push_back(model);
        exp_busy = (op <= 3'd4 && sh != 0) ? int'(sh) + 1 : 1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.shamt = sh;
        tick();
        bus.start = 1'b0;
        bus.op    = 3'($urandom_range(0, 7));
        bus.shamt = 4'($urandom_range(0, 15));
        busy_cnt = 0;
        done_cnt = 0;
        finished = 1'b0;
        got = '0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) begin
                finished = 1'b1;
                break;
            end
            busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                got = bus.dout;
            end
            bus.ld  = inject_ld && (i == 1);
            bus.din = 16'hFFFF;
            tick();
        end
        bus.ld = 1'b0;
        check({tag, " finished"}, 32'(finished), 32'd1);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        want = exp_q.pop_front();
        check({tag, " result"}, 32'(got), 32'(want));
        check({tag, " dout_idle"}, 32'(bus.dout), 32'(want));
    endtask

    initial begin
        bus.ld    = 1'b0;
        bus.din   = '0;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.shamt = '0;
        model     = 16'h0014;

        tick();
        tick();
        check("reset dout", 32'(bus.dout), 32'h0014);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        do_load(16'h8001);
        check("load dout", 32'(bus.dout), 32'h8001);
        run_op("sra3", 3'd2, 4'd3, 1'b0);
        check("sra3 value", 32'(bus.dout), 32'hF000);

        do_load(16'h8001);
        run_op("rol4", 3'd3, 4'd4, 1'b0);
        check("rol4 value", 32'(bus.dout), 32'h0018);

        do_load(16'h0001);
        run_op("ror1", 3'd4, 4'd1, 1'b0);
        check("ror1 value", 32'(bus.dout), 32'h8000);

        run_op("sll0", 3'd0, 4'd0, 1'b0);
        run_op("rsvd7", 3'd7, 4'd5, 1'b0);

        do_load(16'h00F0);
        run_op("ld_ignored", 3'd0, 4'd2, 1'b1);
        check("ld_ignored value", 32'(bus.dout), 32'h03C0);

        do_load(16'h0001);
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.shamt = 4'd15;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("midshift partial", 32'(bus.dout), 32'h0020);
        check("midshift busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst dout", 32'(bus.dout), 32'h0014);
        check("midrst busy", 32'(bus.busy), 32'd0);
        model = 16'h0014;
        run_op("srl2", 3'd1, 4'd2, 1'b0);
        check("srl2 value", 32'(bus.dout), 32'h0005);

        bus.ld    = 1'b1;
        bus.din   = 16'h1234;
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.shamt = 4'd3;
        tick();
        bus.ld    = 1'b0;
        bus.start = 1'b0;
        model     = 16'h1234;
        check("ldstart dout", 32'(bus.dout), 32'h1234);
        check("ldstart busy", 32'(bus.busy), 32'd0);
        tick();
        check("ldstart done", 32'(bus.done), 32'd0);
        check("ldstart busy2", 32'(bus.busy), 32'd0);

        for (int k = 0; k < 6; k++) begin
            do_load(16'($urandom));
            run_op("rand", 3'($urandom_range(0, 4)),
                   4'($urandom_range(0, 15)), 1'b0);
        end

        check("queue empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_shift_reg.md
# seq_shift_reg

Parametrised successor to the 16-bit load register: a WIDTH-bit parallel-in/parallel-out register with parallel load, plus a multi-cycle serial shifter/rotator that moves one bit position per clock under a start/busy/done handshake. It serves as the datapath register behind the RISC CPU's shift and rotate instructions. The controller loads an operand, issues a shift with an amount, and waits for `done`.

## Interface
- `WIDTH`, 16: register width; must be at least 2.
- `RST_VAL`, 20: value of `dout` after reset; WIDTH bits wide.
- `SHAMT_W`, `$clog2(WIDTH)`: shift-amount width; derived, not overridden.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ld`  in  1  parallel-load enable.
- `din`  in  WIDTH  parallel load data.
- `start`  in  1  start-operation request; single-cycle pulse.
- `op`  in  3  operation code: SLL=0, SRL=1, SRA=2, ROL=3, ROR=4; codes 5–7 are reserved.
- `shamt`  in  SHAMT_W  shift amount, 0 to WIDTH-1.
- `dout`  out  WIDTH  register contents.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **Reset:** FSM goes to IDLE, `dout`=RST_VAL, `busy`=0, `done`=0, internal count=0. Reset overrides everything, including an operation in progress.
- **In IDLE:**
  - If `ld`=1: `dout`<=`din`. `ld` takes priority over `start`; a `start` in the same cycle is dropped.
  - Else if `start`=1: `op` and `shamt` are latched internally.
    - `shamt`≠0 and `op` valid: count<=`shamt`, go to SHIFT.
    - `shamt`=0 or `op` reserved: go directly to DONE; `dout` is unchanged.
- **In SHIFT:** each edge applies one 1-bit step of the latched op to `dout` and decrements count. When count==1 at the edge, the final step is applied and the FSM goes to DONE.
- **In DONE:** `done`=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
- **While busy (SHIFT or DONE):** `ld` and `start` are ignored and not queued. `din`, `op` and `shamt` may change freely.
- **1-bit steps:**
  - SLL: shift left, 0 enters at the LSB.
  - SRL: shift right, 0 enters at the MSB.
  - SRA: shift right, the MSB is replicated.
  - ROL: MSB wraps to the LSB.
  - ROR: LSB wraps to the MSB.
- All arithmetic is modulo WIDTH bits. No carry or overflow output.

## Timing
- Edge 0 is the edge where `start` is accepted.
- **`shamt`=N≥1:** `dout` updates at edges 1..N. `done` is high between edges N and N+1. `busy` is high from after edge 0 until edge N+1. Total `busy` cycles = N+1.
- **`shamt`=0 or reserved op:** `done` is high between edges 0 and 1. `busy` is high for 1 cycle.
- **Load:** `ld` latency is 1 cycle; `dout` shows `din` after the edge.
- **Back-to-back operations:** the earliest next `start` is accepted at the edge that returns the FSM to IDLE plus one, i.e. it is sampled in the first IDLE cycle.
- **Reset mid-operation:** on the edge after `rst` is sampled high, the FSM is in IDLE with `dout`=RST_VAL. Any partial shift result is discarded.

## Structure
- **Shared package `shift_pkg`:**
  - `shift_op_e` enum (3-bit: SLL, SRL, SRA, ROL, ROR).
  - `shift_state_e` enum (IDLE, SHIFT, DONE).
  - Function `op_valid(op)`.
- **Sub-module `shift_step`:** combinational 1-bit shifter, parametrised by WIDTH; inputs `din` and `op`, output `dout`. It is instantiated once; the FSM and register live in `seq_shift_reg`.

## Test plan
All scenarios use WIDTH=16, RST_VAL=20.
- **Reset:** assert `rst` for 2 cycles -> `dout`=0x0014, `busy`=0, `done`=0.
- **Arithmetic shift:** `ld` with `din`=0x8001, then `start` with SRA, `shamt`=3 -> `busy` high for 4 cycles, `dout`=0xF000 after edge 3, `done` pulses once in the following cycle.
- **Rotate:** `ld` with `din`=0x8001, then `start` with ROL, `shamt`=4 -> `dout`=0x0018. Repeat with ROR, `shamt`=1 on 0x0001 -> 0x8000.
- **Degenerate ops and ignored requests:**
  - `start` with SLL, `shamt`=0 -> `done` next cycle, `dout` unchanged.
  - `start` with reserved op=7, `shamt`=5 -> same response.
  - `ld` with `din`=0xFFFF during a SHIFT -> ignored; the final result is unaffected.
- **Reset mid-shift:** `start` with SLL, `shamt`=15 on 0x0001; assert `rst` after the 5th shift -> `dout`=0x0014, `busy`=0 next cycle. A new `start` with SRL, `shamt`=2 then gives 0x0005.
- **Same-cycle `ld` and `start` in IDLE:** `din`=0x1234 -> `dout`=0x1234, `busy` stays 0, no `done`.
